// File: rtl/rca_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_tester_pkg
// Description : Shared types, widths and the vector-index split helper for
//               the ripple-carry-adder fault tester.
// Revision    : 1.0 - initial release
// ============================================================================
package rca_tester_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } tester_state_t;

    // Widths at the default operand width; modules derive their own from WIDTH
    localparam int WIDTH_DEF = 4;
    localparam int VEC_W     = 2*WIDTH_DEF + 1;
    localparam int RES_W     = WIDTH_DEF + 1;
    localparam int CNT_W     = 2*WIDTH_DEF + 2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
    } vec_fields_t;

    // idx layout is {a, b, cin} with cin in bit 0
    function automatic vec_fields_t split_idx(input logic [31:0] idx, input int width);
        vec_fields_t f;
        logic [31:0] mask;
        mask  = (32'd1 << width) - 32'd1;
        f.cin = idx[0];
        f.b   = (idx >> 1) & mask;
        f.a   = (idx >> (width + 1)) & mask;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rca_fault_tester_if.sv
`default_nettype none
// ============================================================================
// Module      : rca_fault_tester_if
// Description : Control, adder stimulus/response and result signals of the
//               fault tester. master = tester, slave = board / bench side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rca_fault_tester_if #(
    parameter int WIDTH = 4
);
    import rca_tester_pkg::*;

    logic                 start;
    logic [WIDTH-1:0]     dut_a;
    logic [WIDTH-1:0]     dut_b;
    logic                 dut_cin;
    logic                 dut_cout;
    logic [WIDTH-1:0]     dut_sum;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2*WIDTH+1:0]   err_count;
    logic [2*WIDTH:0]     fail_vec;
    logic [WIDTH:0]       fail_exp;
    logic [WIDTH:0]       fail_got;

    modport master (
        input  start, dut_cout, dut_sum,
        output dut_a, dut_b, dut_cin, busy, done, pass,
               err_count, fail_vec, fail_exp, fail_got
    );

    modport slave (
        output start, dut_cout, dut_sum,
        input  dut_a, dut_b, dut_cin, busy, done, pass,
               err_count, fail_vec, fail_exp, fail_got
    );

endinterface
`default_nettype wire

// File: rtl/rca_golden.sv
`default_nettype none
// ============================================================================
// Module      : rca_golden
// Description : Behavioural reference a+b+cin at full WIDTH+1 precision.
//               Kept apart so the checker never reuses the adder under test.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_golden
    import rca_tester_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic             i_cin,
    output logic      [WIDTH:0]   o_result
);

    // Zero-extend every operand so the carry-out lands in the top bit
    always_comb begin
        o_result = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    end

endmodule
`default_nettype wire

// File: rtl/rca_fault_tester.sv
`default_nettype none
// ============================================================================
// Module      : rca_fault_tester
// Description : Exhaustive {a,b,cin} sweep of an external ripple-carry adder,
//               comparing {cout,sum} against a behavioural golden model and
//               recording error count and the first failing vector.
//               Optional macro RCA_TESTER_STOP_ON_FAIL_EN ends the sweep at
//               the first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_fault_tester
    import rca_tester_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input wire logic clk,
    input wire logic rst_n,
    rca_fault_tester_if.master bus
);

    localparam int          c_vec_w       = 2*WIDTH + 1;
    localparam int          c_res_w       = WIDTH + 1;
    localparam int          c_cnt_w       = 2*WIDTH + 2;
    localparam logic [3:0]  c_settle_last = 4'(SETTLE - 1);

    tester_state_t          r_state;
    logic [c_vec_w-1:0]     r_idx;
    logic [3:0]             r_settle;
    logic [WIDTH-1:0]       r_dut_a;
    logic [WIDTH-1:0]       r_dut_b;
    logic                   r_dut_cin;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [c_cnt_w-1:0]     r_err_count;
    logic [c_vec_w-1:0]     r_fail_vec;
    logic [c_res_w-1:0]     r_fail_exp;
    logic [c_res_w-1:0]     r_fail_got;

    vec_fields_t            w_fields;
    logic [c_res_w-1:0]     w_expected;
    logic [c_res_w-1:0]     w_observed;
    logic                   w_mismatch;
    logic                   w_last;
    logic [c_cnt_w-1:0]     w_err_inc;

    // Golden model looks at the registered stimulus, exactly what the adder sees
    rca_golden #(.WIDTH(WIDTH)) u_golden (
        .i_a      (r_dut_a),
        .i_b      (r_dut_b),
        .i_cin    (r_dut_cin),
        .o_result (w_expected)
    );

    // Decode the index, compare the response and prepare the saturating count
    always_comb begin
        w_fields   = split_idx(32'(r_idx), WIDTH);
        w_observed = {bus.dut_cout, bus.dut_sum};
        w_mismatch = (w_observed != w_expected);
        w_last     = (r_idx == {c_vec_w{1'b1}});
        w_err_inc  = (r_err_count == {c_cnt_w{1'b1}}) ? r_err_count
                                                      : r_err_count + c_cnt_w'(1);
    end

    // Split fields never carry bits above WIDTH
    always_comb begin
        assert (((w_fields.a >> WIDTH) == 32'd0) && ((w_fields.b >> WIDTH) == 32'd0));
    end

    // Sweep sequencer: APPLY -> [WAIT x SETTLE] -> CHECK per vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_settle    <= '0;
            r_dut_a     <= '0;
            r_dut_b     <= '0;
            r_dut_cin   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_vec  <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state     <= APPLY;
                        r_idx       <= '0;
                        r_err_count <= '0;
                        r_fail_vec  <= '0;
                        r_fail_exp  <= '0;
                        r_fail_got  <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                APPLY: begin
                    r_dut_a   <= w_fields.a[WIDTH-1:0];
                    r_dut_b   <= w_fields.b[WIDTH-1:0];
                    r_dut_cin <= w_fields.cin;
                    r_settle  <= '0;
                    if (SETTLE > 0) r_state <= WAIT;
                    else            r_state <= CHECK;
                end
                WAIT: begin
                    if (r_settle == c_settle_last) r_state  <= CHECK;
                    else                           r_settle <= r_settle + 4'd1;
                end
                CHECK: begin
                    if (w_mismatch) begin
                        r_err_count <= w_err_inc;
                        // Only the very first mismatch is recorded
                        if (r_err_count == '0) begin
                            r_fail_vec <= r_idx;
                            r_fail_exp <= w_expected;
                            r_fail_got <= w_observed;
                        end
                    end
`ifdef RCA_TESTER_STOP_ON_FAIL_EN
                    if (w_mismatch || w_last) begin
`else
                    if (w_last) begin
`endif
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= ~w_mismatch & (r_err_count == '0);
                    end else begin
                        r_idx   <= r_idx + c_vec_w'(1);
                        r_state <= APPLY;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.dut_a     = r_dut_a;
    assign bus.dut_b     = r_dut_b;
    assign bus.dut_cin   = r_dut_cin;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;
    assign bus.fail_vec  = r_fail_vec;
    assign bus.fail_exp  = r_fail_exp;
    assign bus.fail_got  = r_fail_got;

endmodule
`default_nettype wire

// File: tb/tb_rca_fault_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_fault_tester
// Description : Directed bench for rca_fault_tester with a behavioural adder
//               that can have sum[0] or cout stuck at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_fault_tester;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 1;
    localparam int LIMIT  = 5000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    int           fault_mode = 0;
    logic [WIDTH:0] adder_res;

    int n_cmp = 0;
    int n_bad = 0;

    rca_fault_tester_if #(.WIDTH(WIDTH)) bus ();

    rca_fault_tester #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Adder under test: 0 = correct, 1 = sum[0] stuck at 0, 2 = cout stuck at 0
    always_comb begin
        adder_res = {1'b0, bus.dut_a} + {1'b0, bus.dut_b} + {{WIDTH{1'b0}}, bus.dut_cin};
        if (fault_mode == 1) adder_res[0]     = 1'b0;
        if (fault_mode == 2) adder_res[WIDTH] = 1'b0;
        bus.dut_cout = adder_res[WIDTH];
        bus.dut_sum  = adder_res[WIDTH-1:0];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Pulse start on one edge and count edges until done rises
    task automatic run_sweep(output int cycles);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cycles = 0;
        while (!bus.done && cycles < LIMIT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    typedef struct {
        int         mode;
        int         cycles;
        logic [9:0] err;
        logic       pass;
        logic [8:0] vec;
        logic [4:0] exp_res;
        logic [4:0] got_res;
        logic [8:0] last_dut;
    } vec_t;

    vec_t tbl[3];

    initial begin
        int cyc;
        bus.start = 1'b0;

        // Sum[0] stuck: every odd total fails (256 of 512), first at idx 1.
        // Cout stuck: totals >= 16 fail: 120 pairs with cin=0 plus 136 with
        // cin=1 = 256; first is a=0,b=15,cin=1 -> idx 0x01F.
`ifdef RCA_TESTER_STOP_ON_FAIL_EN
        tbl[0] = '{0, 1536, 10'd0,   1'b1, 9'h000, 5'h00, 5'h00, 9'h1FF};
        tbl[1] = '{1, 6,    10'd1,   1'b0, 9'h001, 5'h01, 5'h00, 9'h001};
        tbl[2] = '{2, 96,   10'd1,   1'b0, 9'h01F, 5'h10, 5'h00, 9'h01F};
`else
        tbl[0] = '{0, 1536, 10'd0,   1'b1, 9'h000, 5'h00, 5'h00, 9'h1FF};
        tbl[1] = '{1, 1536, 10'd256, 1'b0, 9'h001, 5'h01, 5'h00, 9'h1FF};
        tbl[2] = '{2, 1536, 10'd256, 1'b0, 9'h01F, 5'h10, 5'h00, 9'h1FF};
`endif

        // Reset state
        do_reset();
        check("rst_busy",     32'(bus.busy),      0);
        check("rst_done",     32'(bus.done),      0);
        check("rst_pass",     32'(bus.pass),      0);
        check("rst_err",      32'(bus.err_count), 0);
        check("rst_fail_vec", 32'(bus.fail_vec),  0);
        check("rst_fail_exp", 32'(bus.fail_exp),  0);
        check("rst_fail_got", 32'(bus.fail_got),  0);
        check("rst_dut_vec",  32'({bus.dut_a, bus.dut_b, bus.dut_cin}), 0);

        // Table-driven full sweeps
        for (int i = 0; i < 3; i++) begin
            do_reset();
            fault_mode = tbl[i].mode;
            run_sweep(cyc);
            check($sformatf("t%0d_cycles", i),   32'(cyc),            32'(tbl[i].cycles));
            check($sformatf("t%0d_done", i),     32'(bus.done),       1);
            check($sformatf("t%0d_busy", i),     32'(bus.busy),       0);
            check($sformatf("t%0d_pass", i),     32'(bus.pass),       32'(tbl[i].pass));
            check($sformatf("t%0d_err", i),      32'(bus.err_count),  32'(tbl[i].err));
            check($sformatf("t%0d_fail_vec", i), 32'(bus.fail_vec),   32'(tbl[i].vec));
            check($sformatf("t%0d_fail_exp", i), 32'(bus.fail_exp),   32'(tbl[i].exp_res));
            check($sformatf("t%0d_fail_got", i), 32'(bus.fail_got),   32'(tbl[i].got_res));
            check($sformatf("t%0d_dut_vec", i),
                  32'({bus.dut_a, bus.dut_b, bus.dut_cin}), 32'(tbl[i].last_dut));
        end

        // Start held high in DONE relaunches on the next edge with cleared results
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("held_busy", 32'(bus.busy),      1);
        check("held_done", 32'(bus.done),      0);
        check("held_err",  32'(bus.err_count), 0);

        // Reset mid-sweep aborts and clears everything
        do_reset();
        fault_mode = 1;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        check("abort_err_before", 32'(bus.err_count != 0), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_busy",     32'(bus.busy),      0);
        check("abort_done",     32'(bus.done),      0);
        check("abort_err",      32'(bus.err_count), 0);
        check("abort_fail_vec", 32'(bus.fail_vec),  0);
        fault_mode = 0;
        run_sweep(cyc);
        check("abort_rerun_cycles", 32'(cyc),            1536);
        check("abort_rerun_pass",   32'(bus.pass),       1);
        check("abort_rerun_err",    32'(bus.err_count),  0);

        // Start pulsed while busy is ignored
        do_reset();
`ifdef RCA_TESTER_STOP_ON_FAIL_EN
        fault_mode = 0;
`else
        fault_mode = 1;
`endif
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < LIMIT) begin
            bus.start = (cyc == 99);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            cyc++;
        end
        check("ign_cycles", 32'(cyc), 1536);
`ifdef RCA_TESTER_STOP_ON_FAIL_EN
        check("ign_err", 32'(bus.err_count), 0);
`else
        check("ign_err", 32'(bus.err_count), 256);
`endif

        // Reset and start together: reset wins
        rst_n     = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        check("rst_win_busy", 32'(bus.busy),      0);
        check("rst_win_done", 32'(bus.done),      0);
        check("rst_win_err",  32'(bus.err_count), 0);
        @(posedge clk);
        #1;
        check("rst_win_idle", 32'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
